// File: rtl/hull_fifo_if.sv
// hull_fifo_if: handshake bundle of the hull_fifo elastic queue.
//   wrreq/data  : producer write request and write word
//   full        : queue holds DEPTH words, writes are ignored
//   rdreq       : consumer pop request
//   q           : read word (show-ahead head or registered popped word)
//   empty       : queue holds no words, pops are ignored
// master = producer/consumer side, slave = the FIFO itself.
interface hull_fifo_if #(
    parameter int WIDTH = 64
);
    logic             wrreq;
    logic [WIDTH-1:0] data;
    logic             full;
    logic             rdreq;
    logic [WIDTH-1:0] q;
    logic             empty;

    modport master (
        output wrreq,
        output data,
        output rdreq,
        input  full,
        input  q,
        input  empty
    );

    modport slave (
        input  wrreq,
        input  data,
        input  rdreq,
        output full,
        output q,
        output empty
    );
endinterface

// File: rtl/hull_fifo.sv
// hull_fifo: single-clock FIFO of 2^LOG_DEPTH words of WIDTH bits.
//   clock   : sole clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : hull_fifo_if slave (wrreq, data, full, rdreq, q, empty)
// TYPE 0 = show-ahead (q is the head word while !empty),
// TYPE 1 = registered-read (q loads the popped word after an accepted read).
// full, empty and q are all registers; requests never reach them combinationally.
module hull_fifo #(
    parameter int unsigned TYPE      = 32'd0,
    parameter int          WIDTH     = 64,
    parameter int          LOG_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    hull_fifo_if.slave  bus
);
    localparam int DEPTH = 1 << LOG_DEPTH;
    localparam logic [LOG_DEPTH-1:0] PTR_ONE  = LOG_DEPTH'(1);
    localparam logic [LOG_DEPTH:0]   CNT_ONE  = (LOG_DEPTH + 1)'(1);
    localparam logic [LOG_DEPTH:0]   CNT_FULL = (LOG_DEPTH + 1)'(DEPTH);

    logic [WIDTH-1:0]     mem_r [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr_r;
    logic [LOG_DEPTH-1:0] rd_ptr_r;
    logic [LOG_DEPTH:0]   count_r;
    logic                 full_r;
    logic                 empty_r;
    logic [WIDTH-1:0]     q_r;

    logic                 wr_acc_s;
    logic                 rd_acc_s;
    logic [LOG_DEPTH-1:0] rd_next_s;
    logic [LOG_DEPTH:0]   count_next_s;
    logic [WIDTH-1:0]     head_next_s;

    // Accept decisions, next occupancy and the head word that will be visible after this edge.
    always_comb begin
        wr_acc_s     = bus.wrreq && !full_r;
        rd_acc_s     = bus.rdreq && !empty_r;
        rd_next_s    = rd_ptr_r;
        count_next_s = count_r;
        head_next_s  = '0;

        if (rd_acc_s) begin
            rd_next_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_next_s = rd_ptr_r;
        end

        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase

        // The next head is the word being written this edge only when that
        // slot becomes the head (queue empty or just drained to it).
        if (count_next_s == '0) begin
            head_next_s = '0;
        end else if (wr_acc_s && (rd_next_s == wr_ptr_r)) begin
            head_next_s = bus.data;
        end else begin
            head_next_s = mem_r[rd_next_s];
        end
    end

    // Storage write; contents are deliberately left uncleared by reset.
    always_ff @(posedge clock) begin
        if (wr_acc_s) begin
            mem_r[wr_ptr_r] <= bus.data;
        end
    end

    // Pointers, occupancy, registered flags and read data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            q_r      <= '0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            rd_ptr_r <= rd_next_s;
            count_r  <= count_next_s;
            full_r   <= (count_next_s == CNT_FULL);
            empty_r  <= (count_next_s == '0);
            if (TYPE == 32'd0) begin
                q_r <= head_next_s;
            end else if (rd_acc_s) begin
                q_r <= mem_r[rd_ptr_r];
            end
        end
    end

    assign bus.full  = full_r;
    assign bus.empty = empty_r;
    assign bus.q     = q_r;
endmodule

// File: tb/tb_hull_fifo.sv
// tb_hull_fifo: drives a show-ahead and a registered-read hull_fifo with the
// same stimulus and compares both against a queue-based reference model,
// a hand-written vector table and a few directed corner sequences.
module tb_hull_fifo;
    localparam int WIDTH = 64;
    localparam int DEPTH = 16;

    logic             clock;
    logic             reset_n;
    logic             wr_s;
    logic [WIDTH-1:0] d_s;
    logic             rd_s;

    hull_fifo_if #(.WIDTH(WIDTH)) bus0 ();
    hull_fifo_if #(.WIDTH(WIDTH)) bus1 ();

    assign bus0.wrreq = wr_s;
    assign bus0.data  = d_s;
    assign bus0.rdreq = rd_s;
    assign bus1.wrreq = wr_s;
    assign bus1.data  = d_s;
    assign bus1.rdreq = rd_s;

    hull_fifo #(.TYPE(32'd0), .WIDTH(WIDTH), .LOG_DEPTH(4)) u_sa (
        .clock(clock), .reset_n(reset_n), .bus(bus0));
    hull_fifo #(.TYPE(32'd1), .WIDTH(WIDTH), .LOG_DEPTH(4)) u_rr (
        .clock(clock), .reset_n(reset_n), .bus(bus1));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;

    // reference model: contents as a queue, last popped word for TYPE 1
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] q1_exp;

    typedef struct {
        bit               wr;
        logic [WIDTH-1:0] d;
        bit               rd;
        bit               exp_empty;
        bit               exp_full;
        bit               chk_q0;
        logic [WIDTH-1:0] exp_q0;
        logic [WIDTH-1:0] exp_q1;
    } vec_t;

    vec_t vt[9];

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    endtask

    task automatic check_model();
        check("empty_sa", 64'(bus0.empty), 64'(mq.size() == 0));
        check("full_sa",  64'(bus0.full),  64'(mq.size() == DEPTH));
        check("empty_rr", 64'(bus1.empty), 64'(mq.size() == 0));
        check("full_rr",  64'(bus1.full),  64'(mq.size() == DEPTH));
        check("q_rr", bus1.q, q1_exp);
        if (mq.size() > 0) check("q_sa_head", bus0.q, mq[0]);
    endtask

    // One clock: apply inputs, advance model at the edge, compare 1 time unit later.
    task automatic step(input bit wr, input logic [WIDTH-1:0] d, input bit rd);
        bit wa;
        bit ra;
        wr_s = wr;
        d_s  = d;
        rd_s = rd;
        wa = wr && (mq.size() < DEPTH);
        ra = rd && (mq.size() > 0);
        @(posedge clock);
        cyc++;
        if (ra) q1_exp = mq.pop_front();
        if (wa) mq.push_back(d);
        #1;
        check_model();
    endtask

    task automatic reset_model();
        mq.delete();
        q1_exp = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_empty_sa"}, 64'(bus0.empty), 64'd1);
        check({tag, "_full_sa"},  64'(bus0.full),  64'd0);
        check({tag, "_q_sa"},     bus0.q,          64'd0);
        check({tag, "_empty_rr"}, 64'(bus1.empty), 64'd1);
        check({tag, "_full_rr"},  64'(bus1.full),  64'd0);
        check({tag, "_q_rr"},     bus1.q,          64'd0);
    endtask

    initial begin
        wr_s = 1'b0;
        d_s = '0;
        rd_s = 1'b0;
        reset_n = 1'b0;
        reset_model();

        vt[0] = '{1'b1, 64'h11, 1'b0, 1'b0, 1'b0, 1'b1, 64'h11, 64'h0};
        vt[1] = '{1'b1, 64'h22, 1'b0, 1'b0, 1'b0, 1'b1, 64'h11, 64'h0};
        vt[2] = '{1'b0, 64'h0,  1'b1, 1'b0, 1'b0, 1'b1, 64'h22, 64'h11};
        vt[3] = '{1'b0, 64'h0,  1'b1, 1'b1, 1'b0, 1'b0, 64'h0,  64'h22};
        vt[4] = '{1'b0, 64'h0,  1'b1, 1'b1, 1'b0, 1'b0, 64'h0,  64'h22};
        vt[5] = '{1'b0, 64'h0,  1'b0, 1'b1, 1'b0, 1'b0, 64'h0,  64'h22};
        vt[6] = '{1'b1, 64'h33, 1'b1, 1'b0, 1'b0, 1'b1, 64'h33, 64'h22};
        vt[7] = '{1'b1, 64'h44, 1'b1, 1'b0, 1'b0, 1'b1, 64'h44, 64'h33};
        vt[8] = '{1'b0, 64'h0,  1'b0, 1'b0, 1'b0, 1'b1, 64'h44, 64'h33};

        // reset state
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("rst");
        #2 reset_n = 1'b1;
        @(posedge clock);
        #1;
        step(1'b0, 64'h0, 1'b1);
        check_reset_outputs("rd_empty");

        // vector table (registered-read sequence plus simultaneous ops at the edges)
        for (int i = 0; i < 9; i++) begin
            step(vt[i].wr, vt[i].d, vt[i].rd);
            check($sformatf("tbl%0d_empty", i), 64'(bus0.empty), 64'(vt[i].exp_empty));
            check($sformatf("tbl%0d_full", i),  64'(bus0.full),  64'(vt[i].exp_full));
            check($sformatf("tbl%0d_q_rr", i),  bus1.q,          vt[i].exp_q1);
            if (vt[i].chk_q0) check($sformatf("tbl%0d_q_sa", i), bus0.q, vt[i].exp_q0);
        end
        step(1'b0, 64'h0, 1'b1);
        check("tbl_drained", 64'(bus0.empty), 64'd1);

        // fill and overflow
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 64'(i), 1'b0);
            check($sformatf("fill%0d_full", i), 64'(bus0.full), 64'(i == 15));
        end
        step(1'b1, 64'hAA, 1'b0);
        check("overflow_full", 64'(bus0.full), 64'd1);
        check("overflow_head", bus0.q, 64'h0);
        // simultaneous when full: pop head, drop new word
        step(1'b1, 64'hBB, 1'b1);
        check("full_both_full", 64'(bus0.full), 64'd0);
        check("full_both_head", bus0.q, 64'h1);
        check("full_both_occ", 64'(mq.size()), 64'd15);
        for (int i = 1; i < 16; i++) begin
            check($sformatf("drain%0d_q_sa", i), bus0.q, 64'(i));
            step(1'b0, 64'h0, 1'b1);
        end
        check("drain_empty", 64'(bus0.empty), 64'd1);
        check("drain_q_rr", bus1.q, 64'hF);

        // simultaneous when empty: only the write lands
        step(1'b1, 64'h77, 1'b1);
        check("empty_both_empty", 64'(bus0.empty), 64'd0);
        check("empty_both_q", bus0.q, 64'h77);
        step(1'b0, 64'h0, 1'b1);

        // streaming across four pointer wraps
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 64'h100 + 64'(i), 1'b1);
            check($sformatf("stream%0d_q_sa", i), bus0.q, 64'h100 + 64'(i));
            check($sformatf("stream%0d_full", i), 64'(bus0.full), 64'd0);
            if (i > 0) check($sformatf("stream%0d_q_rr", i), bus1.q, 64'h100 + 64'(i - 1));
        end
        step(1'b0, 64'h0, 1'b1);

        // asynchronous reset with five words queued
        for (int i = 0; i < 5; i++) step(1'b1, 64'h200 + 64'(i), 1'b0);
        wr_s = 1'b0;
        rd_s = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        reset_model();
        check_reset_outputs("async");
        #1 reset_n = 1'b1;
        step(1'b1, 64'h55, 1'b0);
        check("post_rst_q_sa", bus0.q, 64'h55);
        step(1'b0, 64'h0, 1'b1);
        check("post_rst_q_rr", bus1.q, 64'h55);
        check("post_rst_empty", 64'(bus0.empty), 64'd1);
        step(1'b0, 64'h0, 1'b1);
        check("post_rst_hold", bus1.q, 64'h55);

        // randomized traffic against the model, with varying pressure
        for (int i = 0; i < 600; i++) begin
            int bias;
            bias = (i / 150) % 2;
            step(($urandom_range(99) < (bias ? 80 : 40)),
                 {$urandom, $urandom},
                 ($urandom_range(99) < (bias ? 40 : 75)));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
